cko_ccff_cfg_sequencer: RTL and testbench

//  Loads the 7-bit MODE_SEL words of a column of NUM_TILES cko-pad tiles
//  (mmffosc2cko wrappers) through their serial CCFF configuration chain.
//  A host hands over one full image per request. The block then:
//   - shifts the image in;
//   - runs a non-destructive circular read-back pass that checks every bit;
//   - reports done or error.
//  It sits between the fabric config controller and the tile column's ccff_head/ccff_tail.

---
 rtl/cko_cfg_pkg.sv | 15 +
 rtl/cko_cfg_bit_counter.sv | 48 ++++
 rtl/cko_ccff_cfg_sequencer.sv | 172 +++++++++++++++++
 tb/tb_cko_ccff_cfg_sequencer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cko_cfg_pkg.sv
// rtl/cko_cfg_pkg.sv - shared types and defaults for the cko CCFF config sequencer
// Purpose: sequencer state encoding and the default per-tile mode width.
// Ports: none (package).
package cko_cfg_pkg;

    localparam int CKO_MODE_W = 7;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        VERIFY,
        RESP
    } cko_cfg_state_e;

endpackage

// File: rtl/cko_cfg_bit_counter.sv
// rtl/cko_cfg_bit_counter.sv - clear/load/increment counter with terminal-count flag
// Purpose: bit position counter for the chain stream; saturates at MAX_VAL.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   clr             force count to zero (highest priority)
//   load, load_val  load an arbitrary count
//   inc             increment by one, holding at MAX_VAL
//   cnt_q           current count
//   cnt_d           count after the coming clock edge
//   tc              current count equals TC_VAL
module cko_cfg_bit_counter #(
    parameter int W       = 4,
    parameter int TC_VAL  = 13,
    parameter int MAX_VAL = 14
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         inc,
    output logic [W-1:0] cnt_q,
    output logic [W-1:0] cnt_d,
    output logic         tc
);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = load_val;
        end else if (inc && (cnt_q != W'(MAX_VAL))) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    assign tc = (cnt_q == W'(TC_VAL));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/cko_ccff_cfg_sequencer.sv
// rtl/cko_ccff_cfg_sequencer.sv - loads and read-back checks a cko tile column CCFF chain
// Purpose: shifts a host image into the serial chain, then rotates it once more
//   while comparing ccff_tail against the image, and reports done or err.
// Ports:
//   prog_clk, prog_reset_n      clock, asynchronous active-low reset
//   cfg_valid/cfg_ready         host request handshake, cfg_image = full chain image
//   cfg_abort                   cancel a LOAD/VERIFY in progress
//   ccff_head/ccff_shift_en     serial data and shift enable into the chain
//   ccff_tail                   serial data out of the far end of the chain
//   busy, done, err, err_cnt    status; done/err are one-cycle pulses
module cko_ccff_cfg_sequencer
    import cko_cfg_pkg::*;
#(
    parameter  int NUM_TILES = 4,
    parameter  int MODE_W    = CKO_MODE_W,
    localparam int CHAIN_L   = NUM_TILES * MODE_W,
    localparam int CNT_W     = $clog2(CHAIN_L + 1)
) (
    input  logic               prog_clk,
    input  logic               prog_reset_n,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [CHAIN_L-1:0] cfg_image,
    input  logic               cfg_abort,
    output logic               ccff_head,
    output logic               ccff_shift_en,
    input  logic               ccff_tail,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [CNT_W-1:0]   err_cnt
);

    cko_cfg_state_e     state_q, state_d;
    logic [CHAIN_L-1:0] img_q, img_d;
    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
    logic               aborted_q, aborted_d;
    logic               cfg_ready_q, cfg_ready_d;
    logic               head_q, head_d;
    logic               shift_en_q, shift_en_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic               k_clr, k_inc, k_tc;
    logic [CNT_W-1:0]   k_q, k_d;

    // MSB goes out first so it lands at the far (tail) end of the chain.
    function automatic logic stream_bit(input logic [CHAIN_L-1:0] img,
                                        input logic [CNT_W-1:0]   k);
        logic [CNT_W-1:0] idx;
        idx = CNT_W'(CHAIN_L - 1) - k;
        return img[idx];
    endfunction

    cko_cfg_bit_counter #(
        .W       (CNT_W),
        .TC_VAL  (CHAIN_L - 1),
        .MAX_VAL (CHAIN_L)
    ) u_k_cnt (
        .clk      (prog_clk),
        .rst_n    (prog_reset_n),
        .clr      (k_clr),
        .load     (1'b0),
        .load_val ('0),
        .inc      (k_inc),
        .cnt_q    (k_q),
        .cnt_d    (k_d),
        .tc       (k_tc)
    );

    always_comb begin
        state_d     = state_q;
        img_d       = img_q;
        err_cnt_d   = err_cnt_q;
        aborted_d   = aborted_q;
        cfg_ready_d = cfg_ready_q;
        k_clr       = 1'b0;
        k_inc       = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (cfg_valid && cfg_ready_q) begin
                    img_d       = cfg_image;
                    err_cnt_d   = '0;
                    aborted_d   = 1'b0;
                    k_clr       = 1'b1;
                    cfg_ready_d = 1'b0;
                    state_d     = LOAD;
                end
            end
            LOAD: begin
                k_inc = 1'b1;
                if (cfg_abort) begin
                    aborted_d = 1'b1;
                    state_d   = RESP;
                end else if (k_tc) begin
                    k_clr   = 1'b1;
                    state_d = VERIFY;
                end
            end
            VERIFY: begin
                k_inc = 1'b1;
                // The current bit is still compared even when an abort arrives.
                if ((ccff_tail != stream_bit(img_q, k_q)) &&
                    (err_cnt_q != CNT_W'(CHAIN_L))) begin
                    err_cnt_d = err_cnt_q + CNT_W'(1);
                end
                if (cfg_abort) begin
                    aborted_d = 1'b1;
                    state_d   = RESP;
                end else if (k_tc) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                cfg_ready_d = 1'b1;
                state_d     = IDLE;
            end
            default: begin
                cfg_ready_d = 1'b1;
                state_d     = IDLE;
            end
        endcase

        // Outputs are registered, so they are derived from the next state.
        if ((state_d == RESP) && (state_q != RESP)) begin
            done_d = !aborted_d && (err_cnt_d == '0);
            err_d  = aborted_d || (err_cnt_d != '0);
        end
        shift_en_d = (state_d == LOAD) || (state_d == VERIFY);
        head_d     = shift_en_d ? stream_bit(img_d, k_d) : 1'b0;
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            state_q     <= IDLE;
            img_q       <= '0;
            err_cnt_q   <= '0;
            aborted_q   <= 1'b0;
            cfg_ready_q <= 1'b1;
            head_q      <= 1'b0;
            shift_en_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            img_q       <= img_d;
            err_cnt_q   <= err_cnt_d;
            aborted_q   <= aborted_d;
            cfg_ready_q <= cfg_ready_d;
            head_q      <= head_d;
            shift_en_q  <= shift_en_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign cfg_ready     = cfg_ready_q;
    assign ccff_head     = head_q;
    assign ccff_shift_en = shift_en_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;
    assign err_cnt       = err_cnt_q;

endmodule

// File: tb/tb_cko_ccff_cfg_sequencer.sv
// tb/tb_cko_ccff_cfg_sequencer.sv - scoreboard bench for cko_ccff_cfg_sequencer
module tb_cko_ccff_cfg_sequencer;

    localparam int CL = 14;
    localparam int KW = 4;

    logic          prog_clk     = 1'b0;
    logic          prog_reset_n = 1'b1;
    logic          cfg_valid    = 1'b0;
    logic          cfg_abort    = 1'b0;
    logic [CL-1:0] cfg_image    = '0;
    logic          cfg_ready, ccff_head, ccff_shift_en, ccff_tail;
    logic          busy, done, err;
    logic [KW-1:0] err_cnt;

    logic [CL-1:0] chain = '0;
    logic          stuck = 1'b0;
    logic          flip  = 1'b0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [CL-1:0] img;
        bit            ok;
        int            cnt;
        int            lat;
    } exp_t;
    exp_t sb[$];

    always #5 prog_clk = ~prog_clk;

    always @(posedge prog_clk) begin
        if (ccff_shift_en) chain <= {chain[CL-2:0], ccff_head};
    end

    assign ccff_tail = stuck ? 1'b0 : (chain[CL-1] ^ flip);

    cko_ccff_cfg_sequencer #(.NUM_TILES(2)) dut (
        .prog_clk      (prog_clk),
        .prog_reset_n  (prog_reset_n),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_image     (cfg_image),
        .cfg_abort     (cfg_abort),
        .ccff_head     (ccff_head),
        .ccff_shift_en (ccff_shift_en),
        .ccff_tail     (ccff_tail),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .err_cnt       (err_cnt)
    );

    // Starts and ends at a negedge; returns at the negedge of cycle 1 after accept.
    task automatic send(input logic [CL-1:0] img, input bit ok, input int cnt,
                        input int lat, output bit acc);
        exp_t e;
        e.img = img; e.ok = ok; e.cnt = cnt; e.lat = lat;
        sb.push_back(e);
        cfg_image = img;
        cfg_valid = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (cfg_ready) begin
                acc = 1'b1;
                break;
            end
            @(negedge prog_clk);
        end
        if (!acc) begin
            checks++; errors++;
            $display("FAIL accept_timeout: cfg_ready stayed %0b, required 1", cfg_ready);
            void'(sb.pop_back());
        end
        @(negedge prog_clk);
        cfg_valid = 1'b0;
    endtask

    task automatic collect(input int flip_k, input int abort_k, output bit found,
                           output int lat, output logic rd, output logic re,
                           output logic [KW-1:0] rcnt, output int shifts,
                           output logic sh_resp, output logic ready_after);
        found = 0; lat = 0; rd = 0; re = 0; rcnt = '0; shifts = 0;
        sh_resp = 0; ready_after = 0;
        for (int n = 1; n <= 40; n++) begin
            if (ccff_shift_en) shifts++;
            flip      = (flip_k >= 0) && (n == 15 + flip_k);
            cfg_abort = (abort_k >= 0) && (n == 1 + abort_k);
            if (done || err) begin
                found = 1; lat = n; rd = done; re = err; rcnt = err_cnt;
                sh_resp = ccff_shift_en;
                flip = 1'b0; cfg_abort = 1'b0;
                @(negedge prog_clk);
                ready_after = cfg_ready;
                break;
            end
            @(negedge prog_clk);
        end
        flip = 1'b0; cfg_abort = 1'b0;
    endtask

    task automatic test_reset;
        #2 prog_reset_n = 1'b0;
        #1;
        checks++; if (cfg_ready !== 1'b1)     begin errors++; $display("FAIL rst_ready: got %b want 1", cfg_ready); end
        checks++; if (ccff_head !== 1'b0)     begin errors++; $display("FAIL rst_head: got %b want 0", ccff_head); end
        checks++; if (ccff_shift_en !== 1'b0) begin errors++; $display("FAIL rst_shift: got %b want 0", ccff_shift_en); end
        checks++; if (busy !== 1'b0)          begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0)          begin errors++; $display("FAIL rst_done: got %b want 0", done); end
        checks++; if (err !== 1'b0)           begin errors++; $display("FAIL rst_err: got %b want 0", err); end
        checks++; if (err_cnt !== '0)         begin errors++; $display("FAIL rst_errcnt: got %0d want 0", err_cnt); end
        repeat (2) @(negedge prog_clk);
        prog_reset_n = 1'b1;
        @(negedge prog_clk);
    endtask

    task automatic run_and_check(input string name, input logic [CL-1:0] img,
                                 input bit ok, input int cnt, input int lat,
                                 input int flip_k, input int abort_k,
                                 input int exp_shifts, input bit chk_chain);
        bit acc, found;
        int olat, shifts;
        logic rd, re, sh_resp, ready_after;
        logic [KW-1:0] rcnt;
        exp_t e;
        send(img, ok, cnt, lat, acc);
        if (!acc) return;
        collect(flip_k, abort_k, found, olat, rd, re, rcnt, shifts, sh_resp, ready_after);
        e = sb.pop_front();
        checks++;
        if (!found) begin
            errors++; $display("FAIL %s_resp_timeout: no done/err within 40 cycles", name);
            return;
        end
        checks++; if (olat != e.lat)      begin errors++; $display("FAIL %s_latency: got %0d want %0d", name, olat, e.lat); end
        checks++; if (rd !== e.ok)        begin errors++; $display("FAIL %s_done: got %b want %b", name, rd, e.ok); end
        checks++; if (re !== !e.ok)       begin errors++; $display("FAIL %s_err: got %b want %b", name, re, !e.ok); end
        checks++; if (rcnt !== KW'(e.cnt)) begin errors++; $display("FAIL %s_errcnt: got %0d want %0d", name, rcnt, e.cnt); end
        checks++; if (shifts != exp_shifts) begin errors++; $display("FAIL %s_shifts: got %0d want %0d", name, shifts, exp_shifts); end
        checks++; if (sh_resp !== 1'b0)   begin errors++; $display("FAIL %s_shift_in_resp: got %b want 0", name, sh_resp); end
        checks++; if (ready_after !== 1'b1) begin errors++; $display("FAIL %s_ready_after: got %b want 1", name, ready_after); end
        if (chk_chain) begin
            checks++; if (chain !== e.img) begin errors++; $display("FAIL %s_chain: got %h want %h", name, chain, e.img); end
        end
    endtask

    task automatic test_clean_load;
        run_and_check("clean", 14'h2A5C, 1, 0, 29, -1, -1, 28, 1);
    endtask

    task automatic test_stuck_chain;
        stuck = 1'b1;
        run_and_check("stuck", 14'h3FFF, 0, 14, 29, -1, -1, 28, 1);
        stuck = 1'b0;
    endtask

    task automatic test_single_fault;
        run_and_check("flip5", 14'h1234, 0, 1, 29, 5, -1, 28, 1);
    endtask

    task automatic test_abort_load;
        run_and_check("abort", 14'h0F0F, 0, 0, 5, -1, 3, 4, 0);
    endtask

    task automatic test_back_to_back;
        exp_t e;
        int acc_t[$];
        int resp_t[$];
        e.ok = 1; e.cnt = 0; e.lat = 29;
        e.img = 14'h0001; sb.push_back(e);
        e.img = 14'h2000; sb.push_back(e);
        cfg_image = 14'h0001;
        cfg_valid = 1'b1;
        for (int t = 0; t < 90; t++) begin
            if (t == 1) cfg_image = 14'h2000;
            if (cfg_valid && cfg_ready) acc_t.push_back(t);
            if ((done || err) && sb.size() > 0) begin
                e = sb.pop_front();
                resp_t.push_back(t);
                checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_done%0d: got %b want 1", resp_t.size(), done); end
                checks++; if (err_cnt !== '0) begin errors++; $display("FAIL b2b_errcnt%0d: got %0d want 0", resp_t.size(), err_cnt); end
                if (acc_t.size() >= resp_t.size()) begin
                    checks++;
                    if (t - acc_t[resp_t.size()-1] != e.lat) begin
                        errors++; $display("FAIL b2b_latency%0d: got %0d want %0d", resp_t.size(), t - acc_t[resp_t.size()-1], e.lat);
                    end
                end
                if (resp_t.size() == 2) begin
                    checks++; if (chain !== e.img) begin errors++; $display("FAIL b2b_chain: got %h want %h", chain, e.img); end
                end
            end
            if (acc_t.size() == 2 && t > acc_t[1]) cfg_valid = 1'b0;
            if (resp_t.size() == 2) break;
            @(negedge prog_clk);
        end
        cfg_valid = 1'b0;
        checks++;
        if (resp_t.size() != 2 || acc_t.size() != 2) begin
            errors++; $display("FAIL b2b_count: accepts %0d responses %0d want 2 and 2", acc_t.size(), resp_t.size());
        end else begin
            checks++;
            if (acc_t[1] != resp_t[0] + 1) begin
                errors++; $display("FAIL b2b_second_accept: got cycle %0d want %0d", acc_t[1], resp_t[0] + 1);
            end
        end
        @(negedge prog_clk);
        @(negedge prog_clk);
    endtask

    task automatic test_reset_mid_verify;
        bit acc;
        send(14'h1B6D, 1, 0, 29, acc);
        if (!acc) return;
        void'(sb.pop_front());
        repeat (21) @(negedge prog_clk);
        checks++; if (busy !== 1'b1 || ccff_shift_en !== 1'b1) begin errors++; $display("FAIL rstv_pre: busy %b shift %b want 1 1", busy, ccff_shift_en); end
        prog_reset_n = 1'b0;
        #1;
        checks++; if (cfg_ready !== 1'b1)     begin errors++; $display("FAIL rstv_ready: got %b want 1", cfg_ready); end
        checks++; if (ccff_shift_en !== 1'b0) begin errors++; $display("FAIL rstv_shift: got %b want 0", ccff_shift_en); end
        checks++; if (ccff_head !== 1'b0)     begin errors++; $display("FAIL rstv_head: got %b want 0", ccff_head); end
        checks++; if (busy !== 1'b0)          begin errors++; $display("FAIL rstv_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL rstv_pulses: done %b err %b want 0 0", done, err); end
        checks++; if (err_cnt !== '0)         begin errors++; $display("FAIL rstv_errcnt: got %0d want 0", err_cnt); end
        @(negedge prog_clk);
        prog_reset_n = 1'b1;
        @(negedge prog_clk);
        checks++; if (cfg_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL rstv_idle: ready %b busy %b want 1 0", cfg_ready, busy); end
    endtask

    initial begin
        test_reset();
        test_clean_load();
        test_stuck_chain();
        test_single_fault();
        test_abort_load();
        test_back_to_back();
        test_reset_mid_verify();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
